seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the lab board. Latches four BCD digits once per frame and rotates one active-low anode at a time. Drives the shared 7-bit active-low cathode bus through a BCD-to-segment decoder and inserts a blanking window at each digit switch to suppress ghosting. Sits between the stopwatch/counter datapath and the board pins.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_scan_ctrl_digit_decode.sv | 10 +
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, scan-state type and BCD-to-segment decode for the
// seven-segment scan controller.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a blank digit.
  function automatic logic [6:0] seg_of_bcd(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_digit_decode.sv
// Combinational BCD-to-segment decoder applied to the currently selected digit.
module seg_digit_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import seg_pkg::*;

  assign seg = seg_of_bcd(bcd);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-slot blanking
// and blink; leading-zero blanking is built only when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);
  import seg_pkg::*;

  localparam int DIV        = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  if (DEAD_CYCLES <= 0 || DEAD_CYCLES >= DIV) begin : g_bad_dead
    $error("seg_scan_ctrl: DEAD_CYCLES must satisfy 0 < DEAD_CYCLES < DIV");
  end

  scan_state_t               state;
  logic [CNT_W-1:0]          cnt;
  logic [1:0]                idx;
  logic [BLINK_W-1:0]        blink_cnt;
  logic                      blink_on;
  logic                      blink_on_slot;
  logic [4*NUM_DIGITS-1:0]   digits_sh;
  logic [NUM_DIGITS-1:0]     dp_sh;
  logic [NUM_DIGITS-1:0]     blink_sh;
  logic                      frame_tick;
  logic [3:0]                digit_sel;
  logic [6:0]                seg_dec;
  logic                      hide;

  assign frame_tick = en && (cnt == '0) && (idx == 2'd0);
  assign digit_sel  = digits_sh[{idx, 2'b00} +: 4];

  seg_digit_decode u_dec (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  // Blink phase is captured at slot start so a slot is either fully lit or fully dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt     <= '0;
      blink_on      <= 1'b1;
      blink_on_slot <= 1'b1;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
      if (cnt == '0) blink_on_slot <= blink_on;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_sh <= '0;
      dp_sh     <= '0;
      blink_sh  <= '0;
    end else if (frame_tick) begin
      digits_sh <= digits;
      dp_sh     <= dp_mask;
      blink_sh  <= blink_mask;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_next;
  logic [NUM_DIGITS-1:0] lzb_sh;

  // A digit is blank only while it and every more-significant digit are zero.
  always_comb begin
    lzb_next    = '0;
    lzb_next[3] = (digits[15:12] == 4'd0);
    lzb_next[2] = lzb_next[3] && (digits[11:8] == 4'd0);
    lzb_next[1] = lzb_next[2] && (digits[7:4] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             lzb_sh <= '0;
    else if (frame_tick) lzb_sh <= lzb_next;
  end

  assign hide = (blink_sh[idx] && !blink_on_slot) || lzb_sh[idx];
`else
  assign hide = blink_sh[idx] && !blink_on_slot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else if (!en) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_tick;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        BLANK: begin
          an  <= AN_OFF;
          seg <= SEG_BLANK;
          dp  <= 1'b1;
          if (cnt == DEAD_LAST) state <= DRIVE;
        end
        DRIVE: begin
          if (hide) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
          end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_dec;
            dp  <= ~dp_sh[idx];
          end
          if (cnt == CNT_LAST) state <= BLANK;
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: DIV=10, DEAD_CYCLES=2, BLINK_HALF=50.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] digits     = 16'h0000;
  logic [3:0]  dp_mask    = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int passes = 0;

  localparam logic [12:0] DARK = {1'b0, 4'b1111, 7'b1111111, 1'b1};

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  logic [12:0] obs;
  assign obs = {frame_start, an, seg, dp};

  seg_scan_ctrl #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (100),
    .DEAD_CYCLES (2),
    .BLINK_HZ    (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got {fs,an,seg,dp}=%b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 10-cycle slot: 2 dark cycles then 8 driven cycles; frame_start only on the first.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic dp_e, input logic fs_e,
                      input int chg_at = -1, input logic [15:0] chg_val = 16'h0000);
    logic [12:0] exp;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (i < 2) ? DARK : {1'b0, an_e, seg_e, dp_e};
      exp[12] = (i == 0) ? fs_e : 1'b0;
      chk($sformatf("%s c%0d", tag, i), obs, exp);
      if (i == chg_at) digits = chg_val;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] off_frames;

    rst = 1'b1;
    en  = 1'b1;
    digits = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs, DARK);
    rst = 1'b0;

    // Basic scan, two full frames
    for (int f = 0; f < 2; f++) begin
      slot("t1 d0", 4'b1110, S4, 1'b1, 1'b1);
      slot("t1 d1", 4'b1101, S3, 1'b1, 1'b0);
      slot("t1 d2", 4'b1011, S2, 1'b1, 1'b0);
      slot("t1 d3", 4'b0111, S1, 1'b1, 1'b0);
    end

    // Mid-frame digit change is held off until the next frame
    slot("t2 d0", 4'b1110, S4, 1'b1, 1'b1);
    slot("t2 d1", 4'b1101, S3, 1'b1, 1'b0, 4, 16'h5678);
    slot("t2 d2", 4'b1011, S2, 1'b1, 1'b0);
    slot("t2 d3", 4'b0111, S1, 1'b1, 1'b0);
    slot("t2 n0", 4'b1110, S8, 1'b1, 1'b1);
    slot("t2 n1", 4'b1101, S7, 1'b1, 1'b0);
    slot("t2 n2", 4'b1011, S6, 1'b1, 1'b0);
    slot("t2 n3", 4'b0111, S5, 1'b1, 1'b0);

    // Non-decimal code and decimal point
    digits  = 16'h00A9;
    dp_mask = 4'b0010;
    slot("t3 d0", 4'b1110, S9, 1'b1, 1'b1);
    slot("t3 d1", 4'b1101, SB, 1'b0, 1'b0);
`ifdef SEG_SCAN_LZB_EN
    slot("t3 d2", 4'b1111, SB, 1'b1, 1'b0);
    slot("t3 d3", 4'b1111, SB, 1'b1, 1'b0);
`else
    slot("t3 d2", 4'b1011, S0, 1'b1, 1'b0);
    slot("t3 d3", 4'b0111, S0, 1'b1, 1'b0);
`endif

    // Leading zeros
    digits  = 16'h0050;
    dp_mask = 4'b0000;
    slot("t6 d0", 4'b1110, S0, 1'b1, 1'b1);
    slot("t6 d1", 4'b1101, S5, 1'b1, 1'b0);
`ifdef SEG_SCAN_LZB_EN
    slot("t6 d2", 4'b1111, SB, 1'b1, 1'b0);
    slot("t6 d3", 4'b1111, SB, 1'b1, 1'b0);
`else
    slot("t6 d2", 4'b1011, S0, 1'b1, 1'b0);
    slot("t6 d3", 4'b0111, S0, 1'b1, 1'b0);
`endif

    // Asynchronous reset in the middle of a driven slot
    repeat (5) tick();
    chk("pre_rst", obs, {1'b0, 4'b1110, S0, 1'b1});
    #2;
    rst        = 1'b1;
    digits     = 16'h1234;
    blink_mask = 4'b0001;
    #1;
    chk("rst_async", obs, DARK);
    @(posedge clk);
    #1;
    chk("rst_hold", obs, DARK);
    rst = 1'b0;

    // Blink on digit 0: phase toggles every 50 cycles, sampled at slot start
    off_frames = 5'b10100;
    for (int f = 0; f < 5; f++) begin
      if (off_frames[f]) slot($sformatf("t4 f%0d d0", f), 4'b1111, SB, 1'b1, 1'b1);
      else               slot($sformatf("t4 f%0d d0", f), 4'b1110, S4, 1'b1, 1'b1);
      slot($sformatf("t4 f%0d d1", f), 4'b1101, S3, 1'b1, 1'b0);
      slot($sformatf("t4 f%0d d2", f), 4'b1011, S2, 1'b1, 1'b0);
      slot($sformatf("t4 f%0d d3", f), 4'b0111, S1, 1'b1, 1'b0);
    end
    blink_mask = 4'b0000;

    // Enable dropped for 3 cycles in the middle of slot 2
    slot("t5 d0", 4'b1110, S4, 1'b1, 1'b1);
    slot("t5 d1", 4'b1101, S3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5 d2 c%0d", i), obs, (i < 2) ? DARK : {1'b0, 4'b1011, S2, 1'b1});
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 en_low %0d", i), obs, DARK);
    end
    en = 1'b1;
    slot("t5 r0", 4'b1110, S4, 1'b1, 1'b1);
    slot("t5 r1", 4'b1101, S3, 1'b1, 1'b0);
    slot("t5 r2", 4'b1011, S2, 1'b1, 1'b0);
    slot("t5 r3", 4'b0111, S1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
